// File: rtl/axi4l_wb_pkg.sv
// Shared types and constants for the AXI4-Lite to Wishbone bridge.
// Holds the bridge FSM state encoding and the AXI response codes.
// Imported by axi4l_wb_master and its helpers.
package axi4l_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    RESP_W,
    RESP_R
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Wishbone cycle watchdog: counts cycles while enabled, flags the TIMEOUT-th one.
// Ports: clk_i/rst_n_i clock and async active-low reset; clr_i restarts the
// count; en_i counts a cycle; expired_o is high in the last allowed cycle.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of already-elapsed cycles, so the cycle seeing
  // LAST is the TIMEOUT-th one; the owner ends the Wishbone cycle right there.
  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == CW'(LAST));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi4l_wb_master.sv
// AXI4-Lite slave port turning each read/write into one pipelined Wishbone cycle.
// Ports: AXI4-Lite AW/W/B/AR/R channels in, Wishbone master (cyc/stb/we/adr/sel/dat,
// ack/err/rty/stall) out; single outstanding transaction, timeout forces SLVERR.
module axi4l_wb_master
  import axi4l_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [2:0]            awprot_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            wstrb_i,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [1:0]            bresp_o,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [2:0]            arprot_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [31:0]           rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-3:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  state_e                state_q, state_d;
  logic                  run_q, run_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-3:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  rd_pri_q, rd_pri_d;
  logic                  wb_we_q, wb_we_d;
  logic [ADDR_WIDTH-3:0] wb_adr_q, wb_adr_d;
  logic [3:0]            wb_sel_q, wb_sel_d;
  logic [31:0]           wb_dat_q, wb_dat_d;
  logic [1:0]            resp_q, resp_d;
  logic [31:0]           rdata_q, rdata_d;

  logic is_idle, aw_hs, w_hs, wr_pend, wr_full, grant_rd, grant_wr;
  logic slv_term, slv_ok, expired, wb_done;

  logic unused_ok;
  assign unused_ok = ^{awprot_i, arprot_i, awaddr_i[1:0], araddr_i[1:0]};

  // run_q keeps every ready low while reset is asserted and for the first
  // cycle after release, so all outputs read 0 during reset.
  assign is_idle  = (state_q == IDLE) && run_q;
  assign aw_hs    = awvalid_i && awready_o;
  assign w_hs     = wvalid_i && wready_o;
  // A write whose AW and W arrive this very cycle is already eligible.
  assign wr_pend  = is_idle && (aw_held_q || awvalid_i) && (w_held_q || wvalid_i);
  assign wr_full  = aw_held_q && w_held_q;
  assign grant_rd = is_idle && arvalid_i && !wr_full && (!wr_pend || rd_pri_q);
  assign grant_wr = wr_pend && !grant_rd;

  // Slave status only counts once the strobe has been accepted.
  assign slv_term = (wb_ack_i || wb_err_i || wb_rty_i) &&
                    ((state_q == WB_WAIT) || ((state_q == WB_REQ) && !wb_stall_i));
  assign slv_ok   = wb_ack_i && !wb_err_i && !wb_rty_i;
  assign wb_done  = slv_term || expired;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (grant_rd || grant_wr),
    .en_i      (wb_cyc_o),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_rd || grant_wr) state_d = WB_REQ;
      end
      WB_REQ, WB_WAIT: begin
        if (wb_done)                                 state_d = wb_we_q ? RESP_W : RESP_R;
        else if ((state_q == WB_REQ) && !wb_stall_i) state_d = WB_WAIT;
      end
      RESP_W:  if (bready_i) state_d = IDLE;
      RESP_R:  if (rready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    awready_o = is_idle && !aw_held_q;
    wready_o  = is_idle && !w_held_q;
    arready_o = grant_rd;
    wb_cyc_o  = (state_q == WB_REQ) || (state_q == WB_WAIT);
    wb_stb_o  = (state_q == WB_REQ);
    bvalid_o  = (state_q == RESP_W);
    rvalid_o  = (state_q == RESP_R);
  end

  assign bresp_o  = resp_q;
  assign rresp_o  = resp_q;
  assign rdata_o  = rdata_q;
  assign wb_we_o  = wb_we_q;
  assign wb_adr_o = wb_adr_q;
  assign wb_sel_o = wb_sel_q;
  assign wb_dat_o = wb_dat_q;

  always_comb begin
    run_d     = 1'b1;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rd_pri_d  = rd_pri_q;
    wb_we_d   = wb_we_q;
    wb_adr_d  = wb_adr_q;
    wb_sel_d  = wb_sel_q;
    wb_dat_d  = wb_dat_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr_i[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if ((state_q == RESP_W) && bready_i) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end

    // Grant may coincide with the capture handshake, so take live inputs then.
    if (grant_wr) begin
      wb_we_d  = 1'b1;
      wb_adr_d = aw_held_q ? awaddr_q : awaddr_i[ADDR_WIDTH-1:2];
      wb_sel_d = w_held_q ? wstrb_q : wstrb_i;
      wb_dat_d = w_held_q ? wdata_q : wdata_i;
      rd_pri_d = 1'b1;
    end else if (grant_rd) begin
      wb_we_d  = 1'b0;
      wb_adr_d = araddr_i[ADDR_WIDTH-1:2];
      wb_sel_d = 4'b1111;
      rd_pri_d = 1'b0;
    end

    // A slave termination in the final timeout cycle still wins.
    if (wb_done) begin
      resp_d  = (slv_term && slv_ok) ? RESP_OKAY : RESP_SLVERR;
      rdata_d = (slv_term && slv_ok && !wb_we_q) ? wb_dat_i : 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q     <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_pri_q  <= 1'b1;
      wb_we_q   <= 1'b0;
      wb_adr_q  <= '0;
      wb_sel_q  <= '0;
      wb_dat_q  <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      run_q     <= run_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rd_pri_q  <= rd_pri_d;
      wb_we_q   <= wb_we_d;
      wb_adr_q  <= wb_adr_d;
      wb_sel_q  <= wb_sel_d;
      wb_dat_q  <= wb_dat_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4l_wb_master.sv
// Self-checking bench for axi4l_wb_master with a scripted Wishbone slave.
// Expected responses, latencies and cycle lengths come from a transaction-level model.
// Drives directed cases, then randomized transactions with random backpressure.
module tb_axi4l_wb_master;
  import axi4l_wb_pkg::*;

  localparam int AW = 8;
  localparam int TO = 4;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_NONE = 3, K_ACKERR = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i;
  logic          awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
  logic [AW-1:0] awaddr_i, araddr_i;
  logic [2:0]    awprot_i, arprot_i;
  logic [31:0]   wdata_i, rdata_o, wb_dat_o;
  logic [3:0]    wstrb_i, wb_sel_o;
  logic [1:0]    bresp_o, rresp_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-3:0] wb_adr_o;
  logic          slv_ack, slv_err, slv_rty, slv_stall, late_ack;
  logic [31:0]   slv_dat;
  logic          wb_ack_i;

  assign wb_ack_i = slv_ack | late_ack;

  always #5 clk_i = ~clk_i;

  axi4l_wb_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awprot_i(awprot_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arprot_i(arprot_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(slv_dat),
    .wb_ack_i(wb_ack_i), .wb_err_i(slv_err), .wb_rty_i(slv_rty), .wb_stall_i(slv_stall)
  );

  int checks = 0;
  int errors = 0;

  // Slave behaviour for the next Wishbone cycle.
  int          cfg_kind = K_NONE, cfg_stall = 0, cfg_delay = 0;
  logic [31:0] cfg_data = 32'h0;

  // Observations of the most recent Wishbone cycle.
  int          k_cyc = 0, cyc_len = 0, stb_len = 0;
  logic        acc_seen = 1'b0, acc_we = 1'b0;
  logic [AW-3:0] acc_adr = '0;
  logic [3:0]  acc_sel = '0;
  logic [31:0] acc_dat = '0;
  logic        acc_we_q[$];
  logic        hit;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave and monitor in one process so the monitor sees this cycle's stall.
  initial begin
    slv_ack = 0; slv_err = 0; slv_rty = 0; slv_stall = 0; slv_dat = 0;
    forever begin
      @(negedge clk_i);
      if (wb_cyc_o) begin
        if (k_cyc == 0) begin cyc_len = 0; stb_len = 0; acc_seen = 0; end
        k_cyc++;
      end else begin
        k_cyc = 0;
      end
      slv_stall = wb_cyc_o && (k_cyc <= cfg_stall);
      hit       = wb_cyc_o && (k_cyc == cfg_stall + 1 + cfg_delay);
      slv_ack   = hit && (cfg_kind == K_ACK || cfg_kind == K_ACKERR);
      slv_err   = hit && (cfg_kind == K_ERR || cfg_kind == K_ACKERR);
      slv_rty   = hit && (cfg_kind == K_RTY);
      slv_dat   = hit ? cfg_data : $urandom;
      if (wb_cyc_o) begin
        cyc_len++;
        if (wb_stb_o) begin
          stb_len++;
          if (!slv_stall) begin
            acc_seen = 1; acc_we = wb_we_o; acc_adr = wb_adr_o;
            acc_sel = wb_sel_o; acc_dat = wb_dat_o;
            acc_we_q.push_back(wb_we_o);
          end
        end
      end
    end
  end

  // Transaction-level expectation: the slave answers in cycle stall+1+delay of the
  // Wishbone cycle; if that is past TO (or never) the bridge gives up at cycle TO.
  function automatic void model(input int kind, input int stall, input int delay,
                                input logic [31:0] data, input logic is_rd,
                                output logic [1:0] resp, output logic [31:0] rdata,
                                output int clen, output int slen, output logic accepted);
    int t;
    t        = stall + 1 + delay;
    accepted = (stall < TO);
    slen     = accepted ? stall + 1 : TO;
    if (kind != K_NONE && t <= TO) begin
      clen  = t;
      resp  = (kind == K_ACK) ? 2'b00 : 2'b10;
      rdata = (kind == K_ACK && is_rd) ? data : 32'h0;
    end else begin
      clen  = TO;
      resp  = 2'b10;
      rdata = 32'h0;
    end
  endfunction

  task automatic do_txn(input string nm, input logic is_rd, input logic [AW-1:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input int w_lead,
                        input int kind, input int stall, input int delay, input int bp,
                        input logic late);
    logic [1:0]  e_resp, r0;
    logic [31:0] e_rdata, d0;
    int          e_clen, e_slen, t, n, aw_at, w_at;
    logic        e_acc, aw_done, w_done, hs_aw, hs_w, vld;
    model(kind, stall, delay, data, is_rd, e_resp, e_rdata, e_clen, e_slen, e_acc);
    cfg_kind = kind; cfg_stall = stall; cfg_delay = delay; cfg_data = data;
    t = 0;
    if (is_rd) begin
      aw_done = 0;
      arvalid_i = 1; araddr_i = addr;
      while (!aw_done && t < 20) begin
        #1 hs_aw = arready_o;
        @(negedge clk_i); t++;
        if (hs_aw) aw_done = 1;
      end
      arvalid_i = 0;
      check({nm, "_ar_hs"}, aw_done, 1);
    end else begin
      aw_at = (w_lead < 0) ? -w_lead : 0;
      w_at  = (w_lead > 0) ? w_lead : 0;
      aw_done = 0; w_done = 0;
      while (!(aw_done && w_done) && t < 20) begin
        if (!aw_done && t == aw_at) begin awvalid_i = 1; awaddr_i = addr; end
        if (!w_done && t == w_at) begin wvalid_i = 1; wdata_i = data; wstrb_i = strb; end
        #1 hs_aw = awvalid_i && awready_o; hs_w = wvalid_i && wready_o;
        @(negedge clk_i); t++;
        if (hs_aw) begin aw_done = 1; awvalid_i = 0; end
        if (hs_w)  begin w_done = 1; wvalid_i = 0; end
      end
      check({nm, "_aw_w_hs"}, {aw_done, w_done}, 2'b11);
    end
    n = 1;
    vld = is_rd ? rvalid_o : bvalid_o;
    while (!vld && n < 40) begin
      @(negedge clk_i); n++;
      vld = is_rd ? rvalid_o : bvalid_o;
    end
    check({nm, "_valid"}, vld, 1);
    check({nm, "_latency"}, n, e_clen + 1);
    r0 = is_rd ? rresp_o : bresp_o;
    d0 = rdata_o;
    check({nm, "_resp"}, r0, e_resp);
    if (is_rd) check({nm, "_rdata"}, d0, e_rdata);
    check({nm, "_cyc_len"}, cyc_len, e_clen);
    check({nm, "_stb_len"}, stb_len, e_slen);
    if (e_acc) begin
      check({nm, "_wb_we"}, {acc_seen, acc_we}, {1'b1, !is_rd});
      check({nm, "_wb_adr"}, acc_adr, addr[AW-1:2]);
      check({nm, "_wb_sel"}, acc_sel, is_rd ? 4'hf : strb);
      if (!is_rd) check({nm, "_wb_dat"}, acc_dat, data);
    end
    for (int i = 0; i < bp; i++) begin
      if (late && i == 0) late_ack = 1;
      @(negedge clk_i);
      late_ack = 0;
      check({nm, "_bp_hold"}, {(is_rd ? rvalid_o : bvalid_o), (is_rd ? rresp_o : bresp_o)},
            {1'b1, r0});
      if (is_rd) check({nm, "_bp_rdata"}, rdata_o, d0);
    end
    if (is_rd) rready_i = 1; else bready_i = 1;
    @(negedge clk_i);
    rready_i = 0; bready_i = 0;
    check({nm, "_valid_drop"}, {bvalid_o, rvalid_o}, 2'b00);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_axi_out"}, {awready_o, wready_o, bvalid_o, bresp_o, arready_o, rvalid_o,
                             rresp_o, rdata_o}, 64'h0);
    check({nm, "_wb_out"}, {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}, 64'h0);
  endtask

  initial begin
    int base, nb, nr, t;
    logic ba, bw, br;
    logic [1:0] exp_order [4];
    rst_n_i = 0; late_ack = 0;
    awvalid_i = 0; wvalid_i = 0; arvalid_i = 0; bready_i = 0; rready_i = 0;
    awaddr_i = 0; araddr_i = 0; wdata_i = 0; wstrb_i = 0;
    awprot_i = 3'($urandom); arprot_i = 3'($urandom);
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_n_i = 1;
    repeat (2) @(negedge clk_i);
    check("idle_ready", {awready_o, wready_o, arready_o}, 3'b110);

    // Read and write pending together, twice: read wins first, then alternation.
    cfg_kind = K_ACK; cfg_stall = 0; cfg_delay = 0; cfg_data = 32'hCAFE0001;
    base = acc_we_q.size();
    for (int r = 0; r < 2; r++) begin
      awvalid_i = 1; wvalid_i = 1; arvalid_i = 1; awaddr_i = 8'h20; araddr_i = 8'h24;
      wdata_i = 32'h0BADF00D; wstrb_i = 4'hF; bready_i = 1; rready_i = 1;
      nb = 0; nr = 0; t = 0;
      while (!(nb == 1 && nr == 1) && t < 40) begin
        #1 ba = awvalid_i && awready_o; bw = wvalid_i && wready_o; br = arvalid_i && arready_o;
        if (bvalid_o && bready_i) nb++;
        if (rvalid_o && rready_i) nr++;
        @(negedge clk_i); t++;
        if (ba) awvalid_i = 0;
        if (bw) wvalid_i = 0;
        if (br) arvalid_i = 0;
      end
      check("order_round_done", {nb[1:0], nr[1:0]}, 4'b0101);
    end
    bready_i = 0; rready_i = 0;
    check("order_count", acc_we_q.size() - base, 4);
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    for (int i = 0; i < 4; i++)
      if (base + i < acc_we_q.size()) check("order_we", acc_we_q[base + i], exp_order[i][0]);
    @(negedge clk_i);

    // Directed cases.
    do_txn("wr_basic",  0, 8'h14, 32'hDEADBEEF, 4'h3, 2, K_ACK, 0, 0, 0, 0);
    do_txn("rd_stall3", 1, 8'h08, 32'h12345678, 4'h0, 0, K_ACK, 3, 0, 0, 0);
    do_txn("wr_err",    0, 8'h30, 32'h11112222, 4'hC, 0, K_ERR, 1, 1, 0, 0);
    do_txn("rd_rty",    1, 8'h34, 32'h55AA55AA, 4'h0, 0, K_RTY, 0, 2, 0, 0);
    do_txn("rd_ackerr", 1, 8'h38, 32'h77777777, 4'h0, 0, K_ACKERR, 0, 1, 0, 0);
    do_txn("rd_tmo",    1, 8'h3C, 32'h99999999, 4'h0, 0, K_NONE, 0, 0, 3, 1);
    do_txn("wr_tmo_st", 0, 8'h40, 32'h01020304, 4'hF, -1, K_ACK, 6, 0, 0, 0);
    do_txn("wr_bp5",    0, 8'hFC, 32'hA5A5A5A5, 4'h9, -2, K_ACK, 0, 1, 5, 0);

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      int kr, kind;
      kr = $urandom_range(0, 9);
      kind = (kr <= 5) ? K_ACK : (kr == 6) ? K_ERR : (kr == 7) ? K_RTY :
             (kr == 8) ? K_NONE : K_ACKERR;
      do_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 8'($urandom), $urandom,
             4'($urandom_range(1, 15)), $urandom_range(0, 4) - 2, kind,
             $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 2), 0);
    end

    // Reset while the slave is silent in WB_WAIT: everything drops immediately.
    cfg_kind = K_NONE; cfg_stall = 0; cfg_delay = 0;
    arvalid_i = 1; araddr_i = 8'h10; t = 0; br = 0;
    while (!br && t < 20) begin
      #1 br = arready_o;
      @(negedge clk_i); t++;
    end
    arvalid_i = 0;
    check("rst_mid_ar_hs", br, 1);
    @(negedge clk_i);
    check("rst_mid_in_wait", {wb_cyc_o, wb_stb_o}, 2'b10);
    rst_n_i = 0;
    #1 check_all_zero("rst_mid");
    @(negedge clk_i);
    rst_n_i = 1;
    repeat (2) @(negedge clk_i);
    check("rst_mid_no_resp", {bvalid_o, rvalid_o}, 2'b00);
    do_txn("post_rst_wr", 0, 8'h44, 32'hFEEDFACE, 4'hF, 0, K_ACK, 0, 0, 1, 0);
    do_txn("post_rst_rd", 1, 8'h44, 32'h0C0FFEE0, 4'h0, 0, K_ACK, 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
